// File: rtl/cla_addsub_seq.sv
// rtl/cla_addsub_seq.sv - multi-cycle group carry-lookahead adder/subtractor
module cla_addsub_seq #(
    parameter int WIDTH = 16,
    parameter int GRP   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NGRP = WIDTH / GRP;
    localparam int IW   = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam logic [IW-1:0] LAST = IW'(NGRP - 1);

    if ((GRP < 1) || (WIDTH < GRP) || ((WIDTH % GRP) != 0)) begin : g_bad_param
        $error("cla_addsub_seq: WIDTH must be a non-zero multiple of GRP");
    end

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    state_t           state_nx;
    logic [IW-1:0]    idx;
    logic             carry;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] bx_r;
    logic [GRP-1:0]   ga;
    logic [GRP-1:0]   gb;
    logic [GRP-1:0]   p;
    logic [GRP-1:0]   g;
    logic [GRP-1:0]   s;
    // cc[0] is the incoming group carry, cc[i+1] is the carry out of bit i
    logic [GRP:0]     cc;
    logic             acc;
    logic             term;

    assign busy = (state == RUN);

    // Select the operand slices of the group currently being evaluated
    always_comb begin
        ga = '0;
        gb = '0;
        for (int k = 0; k < NGRP; k++) begin
            if (idx == IW'(k)) begin
                ga = a_r[k*GRP +: GRP];
                gb = bx_r[k*GRP +: GRP];
            end
        end
    end

    // Fully expanded lookahead carries for one group (sum of products, no ripple)
    always_comb begin
        p     = ga ^ gb;
        g     = ga & gb;
        cc    = '0;
        acc   = 1'b0;
        term  = 1'b0;
        cc[0] = carry;
        for (int i = 0; i < GRP; i++) begin
            acc = carry;
            for (int j = 0; j <= i; j++) begin
                acc = acc & p[j];
            end
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int k = j + 1; k <= i; k++) begin
                    term = term & p[k];
                end
                acc = acc | term;
            end
            cc[i+1] = acc;
        end
        s = p ^ cc[GRP-1:0];
    end

    // Next-state logic: run one group per cycle, return to idle after the last group
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (idx == LAST) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register, operand latch, per-group result write and completion flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            carry <= 1'b0;
            a_r   <= '0;
            bx_r  <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    a_r   <= a;
                    bx_r  <= sub ? ~b : b;
                    carry <= sub | cin;
                    idx   <= '0;
                end
            end else begin
                for (int k = 0; k < NGRP; k++) begin
                    if (idx == IW'(k)) sum[k*GRP +: GRP] <= s;
                end
                carry <= cc[GRP];
                idx   <= idx + 1'b1;
                if (idx == LAST) begin
                    idx  <= '0;
                    done <= 1'b1;
                    cout <= cc[GRP];
                    ovf  <= cc[GRP] ^ cc[GRP-1];
                end
            end
        end
    end
endmodule
